// File: rtl/avalon_hs_bridge.sv
// Avalon-MM slave to SDRAM host-port bridge: posted writes, stalled reads,
// bounded wait for Done with a sticky timeout flag.
module avalon_hs_bridge #(
   parameter int ASIZE   = 22,
   parameter int DSIZE   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [ASIZE-1:0] avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [DSIZE-1:0] avs_writedata,
   output logic [DSIZE-1:0] avs_readdata,
   output logic             avs_waitrequest,
   output logic [ASIZE-1:0] oHS_ADDR,
   output logic [DSIZE-1:0] oHS_DATA,
   output logic             oHS_RD,
   output logic             oHS_WR,
   input  logic [DSIZE-1:0] iHS_DATA,
   input  logic             iHS_Done,
   input  logic             iERR_CLR,
   output logic             oERR,
   output logic             oBUSY
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, RD_DONE, GAP} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [ASIZE-1:0] r_addr;
   logic [DSIZE-1:0] r_data;
   logic [DSIZE-1:0] r_rdata;
   logic             r_rd;
   logic             r_wr;
   logic             r_err;

   state_t           w_state_nxt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [ASIZE-1:0] w_addr_nxt;
   logic [DSIZE-1:0] w_data_nxt;
   logic [DSIZE-1:0] w_rdata_nxt;
   logic             w_rd_nxt;
   logic             w_wr_nxt;
   logic             w_err_set;
   logic             w_timeout;

   assign w_timeout = (r_cnt == CNT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_data_nxt  = r_data;
      w_rdata_nxt = r_rdata;
      w_rd_nxt    = r_rd;
      w_wr_nxt    = r_wr;
      w_err_set   = 1'b0;
      unique case (r_state)
         IDLE: begin
            // read wins a simultaneous request; the write keeps stalling
            if (avs_read) begin
               w_addr_nxt  = avs_address;
               w_rd_nxt    = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = RD_REQ;
            end else if (avs_write) begin
               w_addr_nxt  = avs_address;
               w_data_nxt  = avs_writedata;
               w_wr_nxt    = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = WR_REQ;
            end
         end
         WR_REQ: begin
            if (iHS_Done || w_timeout) begin
               w_wr_nxt    = 1'b0;
               w_err_set   = ~iHS_Done;
               w_state_nxt = GAP;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RD_REQ: begin
            if (iHS_Done) begin
               w_rd_nxt    = 1'b0;
               w_rdata_nxt = iHS_DATA;
               w_state_nxt = RD_DONE;
            end else if (w_timeout) begin
               w_rd_nxt    = 1'b0;
               w_rdata_nxt = '0;
               w_err_set   = 1'b1;
               w_state_nxt = RD_DONE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RD_DONE: w_state_nxt = IDLE;
         GAP:     w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_rdata <= '0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_addr  <= w_addr_nxt;
         r_data  <= w_data_nxt;
         r_rdata <= w_rdata_nxt;
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_err   <= w_err_set | (r_err & ~iERR_CLR);
      end
   end

   assign avs_waitrequest = iRST |
      ~(((r_state == IDLE) && avs_write && !avs_read) || (r_state == RD_DONE));
   assign avs_readdata = r_rdata;
   assign oHS_ADDR     = r_addr;
   assign oHS_DATA     = r_data;
   assign oHS_RD       = r_rd;
   assign oHS_WR       = r_wr;
   assign oERR         = r_err;
   assign oBUSY        = (r_state != IDLE);

endmodule

// File: tb/tb_avalon_hs_bridge.sv
// Scoreboard bench for avalon_hs_bridge: stimulus queues expected host commands
// and read data; a negedge monitor checks them as the DUT presents them.
module tb_avalon_hs_bridge;

   localparam int ASIZE = 22;
   localparam int DSIZE = 16;
   localparam int TO    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [ASIZE-1:0] avs_address = '0;
   logic             avs_read = 1'b0;
   logic             avs_write = 1'b0;
   logic [DSIZE-1:0] avs_writedata = '0;
   logic [DSIZE-1:0] avs_readdata;
   logic             avs_waitrequest;
   logic [ASIZE-1:0] hs_addr;
   logic [DSIZE-1:0] hs_data;
   logic             hs_rd;
   logic             hs_wr;
   logic [DSIZE-1:0] hs_rdata = '0;
   logic             hs_done = 1'b0;
   logic             err_clr = 1'b0;
   logic             err;
   logic             busy;

   avalon_hs_bridge #(.ASIZE(ASIZE), .DSIZE(DSIZE), .TIMEOUT(TO)) dut (
      .iCLK(clk), .iRST(rst),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
      .avs_waitrequest(avs_waitrequest),
      .oHS_ADDR(hs_addr), .oHS_DATA(hs_data), .oHS_RD(hs_rd), .oHS_WR(hs_wr),
      .iHS_DATA(hs_rdata), .iHS_Done(hs_done),
      .iERR_CLR(err_clr), .oERR(err), .oBUSY(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit               wr;
      logic [ASIZE-1:0] addr;
      logic [DSIZE-1:0] data;
      int               len;
   } cmd_t;

   cmd_t             q_host[$];
   logic [DSIZE-1:0] q_rd[$];
   int n_chk  = 0;
   int n_pass = 0;
   int cyc_cnt = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // monitor: host command issue/length and Avalon read completions
   cmd_t cur;
   bit   act_cmd = 0;
   int   len = 0;
   logic prev_rd = 0, prev_wr = 0;

   always @(negedge clk) begin
      if (rst) begin
         act_cmd = 0;
         prev_rd = 0;
         prev_wr = 0;
      end else begin
         if ((hs_wr && !prev_wr) || (hs_rd && !prev_rd)) begin
            if (q_host.size() == 0) begin
               chk("host_unexpected_cmd", 32'(q_host.size()), 32'd1);
            end else begin
               cur = q_host.pop_front();
               chk("host_cmd_is_wr", 32'(hs_wr), 32'(cur.wr));
               chk("host_addr", 32'(hs_addr), 32'(cur.addr));
               if (cur.wr) chk("host_wdata", 32'(hs_data), 32'(cur.data));
               act_cmd = 1;
               len = 0;
            end
         end
         if (act_cmd && (hs_wr || hs_rd)) len++;
         if (act_cmd && !hs_wr && !hs_rd) begin
            chk("strobe_len", 32'(len), 32'(cur.len));
            act_cmd = 0;
         end
         if (avs_read && !avs_waitrequest) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 32'(q_rd.size()), 32'd1);
            else chk("avs_readdata", 32'(avs_readdata), 32'(q_rd.pop_front()));
         end
         prev_rd = hs_rd;
         prev_wr = hs_wr;
      end
   end

   task automatic do_done(input int d, input logic [DSIZE-1:0] rdata);
      if (d > 0) begin
         repeat (d - 1) begin @(posedge clk); #1; end
         hs_done  = 1'b1;
         hs_rdata = rdata;
         @(posedge clk); #1;
         hs_done = 1'b0;
      end
   endtask

   task automatic do_write(input logic [ASIZE-1:0] a, input logic [DSIZE-1:0] d, input int dl);
      cmd_t c;
      c.wr = 1; c.addr = a; c.data = d; c.len = dl;
      q_host.push_back(c);
      avs_address = a; avs_writedata = d; avs_write = 1'b1;
      @(negedge clk);
      chk("wr_accept_waitreq", 32'(avs_waitrequest), 32'd0);
      @(posedge clk); #1;
      avs_write = 1'b0;
      do_done(dl, '0);
      @(negedge clk);
      chk("gap_busy", 32'(busy), 32'd1);
      chk("gap_wr_low", 32'(hs_wr), 32'd0);
      @(negedge clk);
      chk("idle_after_gap", 32'(busy), 32'd0);
      @(posedge clk); #1;
   endtask

   // dl = 0 means Done never arrives (timeout path)
   task automatic do_read(input logic [ASIZE-1:0] a, input int dl,
                          input logic [DSIZE-1:0] rdata, input logic [DSIZE-1:0] exp);
      cmd_t c;
      int t0;
      bit got = 0;
      c.wr = 0; c.addr = a; c.data = '0; c.len = (dl > 0) ? dl : TO;
      q_host.push_back(c);
      q_rd.push_back(exp);
      avs_address = a; avs_read = 1'b1;
      @(posedge clk); #1;
      t0 = cyc_cnt;
      do_done(dl, rdata);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!avs_waitrequest) begin got = 1; break; end
      end
      chk("rd_completed", 32'(got), 32'd1);
      chk("rd_latency", 32'(cyc_cnt - t0), 32'((dl > 0) ? dl : TO));
      @(posedge clk); #1;
      avs_read = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cmd_t c;
      #1 rst = 1'b1;
      avs_write = 1'b1;
      #2;
      chk("rst_waitreq", 32'(avs_waitrequest), 32'd1);
      chk("rst_addr", 32'(hs_addr), 32'd0);
      chk("rst_data", 32'(hs_data), 32'd0);
      chk("rst_rd", 32'(hs_rd), 32'd0);
      chk("rst_wr", 32'(hs_wr), 32'd0);
      chk("rst_readdata", 32'(avs_readdata), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      avs_write = 1'b0;
      repeat (2) @(posedge clk); #1;

      do_write(22'h000123, 16'hBEEF, 4);
      chk("wr_no_err", 32'(err), 32'd0);

      do_read(22'h3FFFFF, 1, 16'h5A5A, 16'h5A5A);
      do_write(22'h000200, 16'h0001, 1);

      // spurious Done in IDLE must not disturb state or readdata
      hs_rdata = 16'h1111; hs_done = 1'b1;
      @(posedge clk); #1;
      hs_done = 1'b0;
      @(negedge clk);
      chk("spur_busy", 32'(busy), 32'd0);
      chk("spur_strobes", 32'({hs_rd, hs_wr}), 32'd0);
      chk("spur_readdata", 32'(avs_readdata), 32'h5A5A);
      @(posedge clk); #1;

      do_read(22'h001000, 0, 16'hFFFF, 16'h0000);
      repeat (2) @(negedge clk);
      chk("timeout_err_set", 32'(err), 32'd1);
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_cleared", 32'(err), 32'd0);
      @(posedge clk); #1;

      // simultaneous read+write: read first, write stalls until IDLE
      c.wr = 0; c.addr = 22'h00ABCD; c.data = '0; c.len = 1; q_host.push_back(c);
      c.wr = 1; c.data = 16'h7E57; q_host.push_back(c);
      q_rd.push_back(16'hC3C3);
      avs_address = 22'h00ABCD; avs_writedata = 16'h7E57;
      avs_read = 1'b1; avs_write = 1'b1;
      @(negedge clk);
      chk("both_waitreq", 32'(avs_waitrequest), 32'd1);
      @(posedge clk); #1;
      hs_done = 1'b1; hs_rdata = 16'hC3C3;
      @(negedge clk);
      chk("both_rdreq_waitreq", 32'(avs_waitrequest), 32'd1);
      chk("both_rd_first", 32'({hs_rd, hs_wr}), 32'b10);
      @(posedge clk); #1;
      hs_done = 1'b0;
      @(posedge clk); #1;
      avs_read = 1'b0;
      @(negedge clk);
      chk("both_wr_accept", 32'(avs_waitrequest), 32'd0);
      @(posedge clk); #1;
      avs_write = 1'b0;
      hs_done = 1'b1;
      @(posedge clk); #1;
      hs_done = 1'b0;
      repeat (3) @(posedge clk); #1;

      // reset during RD_REQ abandons the read
      c.wr = 0; c.addr = 22'h0000AA; c.data = '0; c.len = 0; q_host.push_back(c);
      avs_address = 22'h0000AA; avs_read = 1'b1;
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("rst_mid_rd", 32'(hs_rd), 32'd0);
      chk("rst_mid_waitreq", 32'(avs_waitrequest), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      avs_read = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", 32'(busy), 32'd0);
      @(posedge clk); #1;
      do_write(22'h000055, 16'h1234, 2);

      for (int i = 0; i < 20 && (q_host.size() != 0 || q_rd.size() != 0); i++)
         @(posedge clk);
      chk("host_queue_drained", 32'(q_host.size()), 32'd0);
      chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/avalon_hs_bridge.md
# avalon_hs_bridge

Avalon-MM slave that converts single-word Avalon reads and writes into host-side SDRAM transactions (address, data, RD/WR strobe, Done). It is the initiator for the SDRAM multiplexer's host port and sits between the Nios/Avalon fabric and that port. It provides posted writes, stalled reads, a Done timeout and a sticky error flag.

## Interface
Parameters:
- ASIZE, 22, word address width of the host port
- DSIZE, 16, data width
- TIMEOUT, 255, maximum cycles the bridge waits for Done per transaction (≥2)

Ports:
- iCLK  in  1  clock
- iRST  in  1  asynchronous, active-high reset
- avs_address  in  ASIZE  Avalon word address
- avs_read  in  1  Avalon read request
- avs_write  in  1  Avalon write request
- avs_writedata  in  DSIZE  Avalon write data
- avs_readdata  out  DSIZE  Avalon read data, valid when avs_read=1 and avs_waitrequest=0
- avs_waitrequest  out  1  Avalon stall
- oHS_ADDR  out  ASIZE  host-port address (registered)
- oHS_DATA  out  DSIZE  host-port write data (registered)
- oHS_RD  out  1  host-port read strobe (registered)
- oHS_WR  out  1  host-port write strobe (registered)
- iHS_DATA  in  DSIZE  host-port read data, valid in the cycle iHS_Done=1
- iHS_Done  in  1  host-port completion
- iERR_CLR  in  1  clears oERR
- oERR  out  1  sticky timeout flag
- oBUSY  out  1  state ≠ IDLE

## Operation
- States: IDLE, WR_REQ, RD_REQ, RD_DONE, GAP.
- avs_waitrequest = 0 only in two cases: (a) IDLE with avs_write=1 and avs_read=0; (b) RD_DONE. It is 1 otherwise, and forced to 1 while iRST=1.
- IDLE + avs_read: latch avs_address into oHS_ADDR, go to RD_REQ, set oHS_RD=1. Read has priority if read and write are both asserted; the write stalls.
- IDLE + avs_write (read=0): the write is accepted (posted) that edge. Latch address and data, go to WR_REQ, set oHS_WR=1.
- WR_REQ / RD_REQ: the strobe is held while iHS_Done=0. An edge sampling iHS_Done=1 does the following:
  - clears the strobe;
  - for a read, captures iHS_DATA into avs_readdata and goes to RD_DONE;
  - for a write, goes to GAP.
- RD_DONE: one cycle with avs_waitrequest=0 (read completes), then IDLE.
- GAP: one idle cycle, then IDLE. This guarantees at least one strobe-low cycle between host commands; RD_DONE serves the same purpose for reads.
- Timeout counter:
  - cleared on entry to WR_REQ/RD_REQ; increments each cycle in those states.
  - If it reaches TIMEOUT-1 with iHS_Done=0: clear the strobe and set oERR=1.
  - A write then goes to GAP.
  - A read goes to RD_DONE with avs_readdata=0.
- oERR: set on timeout; cleared by iERR_CLR=1 or iRST. Set wins if both occur in the same cycle.
- iHS_Done while in IDLE, GAP or RD_DONE is ignored and does not change iHS_DATA capture.
- Address and data widths pass through unchanged; no arithmetic on addresses.

## Timing
- Reset values: oHS_ADDR=0, oHS_DATA=0, oHS_RD=0, oHS_WR=0, avs_readdata=0, oERR=0, oBUSY=0, avs_waitrequest=1, state IDLE, counter 0.
- iRST mid-transaction: strobes drop immediately (asynchronous); the pending read is abandoned.
- Write: accepted at edge N; oHS_WR=1 from N through the edge that samples Done (edge D); oHS_WR=0 after D; GAP cycle; next command accepted no earlier than edge D+2.
- Read: issued at edge N; oHS_RD=1 after N. Done sampled at edge D. Data on avs_readdata with waitrequest=0 in the cycle after D. Minimum read latency is 2 cycles from request to data when Done arrives the first cycle.
- Back-to-back writes: at most one write per 3 cycles with an immediate Done.

## Test plan
- Write A=0x000123, D=0xBEEF, Done 4 cycles later → waitrequest=0 at acceptance. oHS_WR high for exactly 4 cycles with oHS_ADDR=0x000123 and oHS_DATA=0xBEEF. One GAP cycle follows. oERR=0.
- Read A=0x3FFFFF, Done on first cycle with iHS_DATA=0x5A5A → avs_readdata=0x5A5A with waitrequest=0 two cycles after the request; oHS_RD high exactly 1 cycle.
- Read with Done never asserted, TIMEOUT=8 → oHS_RD drops after 8 cycles. Read completes with readdata=0. oERR=1 until an iERR_CLR pulse clears it.
- Simultaneous avs_read and avs_write in IDLE → read issued first. Write stalls (waitrequest=1) until IDLE, then is accepted.
- Spurious iHS_Done in IDLE with iHS_DATA=0x1111 → no state change and avs_readdata unchanged.
- iRST asserted mid-RD_REQ → oHS_RD=0 and waitrequest=1 immediately. After release, the bridge is in IDLE and a new write completes normally.
